// File: rtl/pcs_rx_oset_decode.sv
// 1000BASE-X PCS receive ordered-set decoder: RUDI / rx_Config_Reg for AN, /S/../T/ packet recovery.
// Optional saturating invalid-event counter enabled by defining PCS_RX_ERR_CNT_EN.
module pcs_rx_oset_decode #(
    parameter int ERR_CNT_W      = 16,
    parameter bit SOP_AFTER_IDLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_is_k,
    input  logic                 rx_valid,
    input  logic                 rx_code_err,
    input  logic                 sync_status,
    output logic [1:0]           RUDI,
    output logic [15:0]          rx_Config_Reg,
    output logic                 rx_cfg_valid,
    output logic [7:0]           rxd,
    output logic                 rx_dv,
    output logic                 rx_er,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;

    typedef enum logic [2:0] {
        WAIT_K,
        GOT_K,
        CFG_LO,
        CFG_HI,
        RX_PKT
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cfg_lo, cfg_lo_n;
    logic [1:0]  rudi_n;
    logic [15:0] cfg_n;
    logic        cfg_valid_n;
    logic [7:0]  rxd_n;
    logic        dv_n;
    logic        er_n;
    logic        invalid;
    logic        sop_ok;

    assign sop_ok = !SOP_AFTER_IDLE || (RUDI == 2'b01);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= WAIT_K;
            cfg_lo        <= 8'h00;
            RUDI          <= 2'b00;
            rx_Config_Reg <= 16'h0000;
            rx_cfg_valid  <= 1'b0;
            rxd           <= 8'h00;
            rx_dv         <= 1'b0;
            rx_er         <= 1'b0;
        end else begin
            state         <= state_n;
            cfg_lo        <= cfg_lo_n;
            RUDI          <= rudi_n;
            rx_Config_Reg <= cfg_n;
            rx_cfg_valid  <= cfg_valid_n;
            rxd           <= rxd_n;
            rx_dv         <= dv_n;
            rx_er         <= er_n;
        end
    end

    // Loss of sync wins over everything; otherwise only qualified code-groups advance the FSM.
    always_comb begin
        state_n     = state;
        cfg_lo_n    = cfg_lo;
        rudi_n      = RUDI;
        cfg_n       = rx_Config_Reg;
        cfg_valid_n = 1'b0;
        rxd_n       = rxd;
        dv_n        = 1'b0;
        er_n        = 1'b0;
        invalid     = 1'b0;

        if (!sync_status) begin
            state_n = WAIT_K;
            rudi_n  = 2'b11;
        end else if (rx_valid) begin
            case (state)
                WAIT_K: begin
                    if (rx_is_k && !rx_code_err && rx_data == K28_5) begin
                        state_n = GOT_K;
                    end else if (rx_is_k && !rx_code_err && rx_data == K27_7 && sop_ok) begin
                        state_n = RX_PKT;
                    end else begin
                        invalid = 1'b1;
                    end
                end
                GOT_K: begin
                    if (rx_code_err) begin
                        invalid = 1'b1;
                        state_n = WAIT_K;
                    end else if (!rx_is_k && (rx_data == D21_5 || rx_data == D2_2)) begin
                        state_n = CFG_LO;
                    end else if (!rx_is_k && (rx_data == D5_6 || rx_data == D16_2)) begin
                        rudi_n  = 2'b01;
                        state_n = WAIT_K;
                    end else if (rx_is_k && rx_data == K28_5) begin
                        invalid = 1'b1;
                    end else begin
                        invalid = 1'b1;
                        state_n = WAIT_K;
                    end
                end
                CFG_LO, CFG_HI: begin
                    if (rx_is_k || rx_code_err) begin
                        invalid = 1'b1;
                        state_n = (rx_is_k && rx_data == K28_5) ? GOT_K : WAIT_K;
                    end else if (state == CFG_LO) begin
                        cfg_lo_n = rx_data;
                        state_n  = CFG_HI;
                    end else begin
                        cfg_n       = {rx_data, cfg_lo};
                        rudi_n      = 2'b10;
                        cfg_valid_n = 1'b1;
                        state_n     = WAIT_K;
                    end
                end
                RX_PKT: begin
                    invalid = rx_code_err;
                    if (!rx_is_k) begin
                        rxd_n = rx_data;
                        dv_n  = 1'b1;
                        er_n  = rx_code_err;
                    end else if (rx_data == K29_7) begin
                        state_n = WAIT_K;
                    end else if (rx_data == K28_5) begin
                        er_n    = 1'b1;
                        invalid = 1'b1;
                        state_n = GOT_K;
                    end else begin
                        rxd_n = rx_data;
                        dv_n  = 1'b1;
                        er_n  = 1'b1;
                    end
                end
                default: state_n = WAIT_K;
            endcase
            if (invalid) begin
                rudi_n = 2'b11;
            end
        end
    end

`ifdef PCS_RX_ERR_CNT_EN
    logic                 sync_q;
    logic                 count_inc;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // A sync loss counts once, on its falling edge, not for every cycle it stays low.
    assign count_inc = invalid || (sync_q && !sync_status);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sync_q <= sync_status;
            if (count_inc && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
